rob_nway_recover: RTL and testbench

- N-wide reorder buffer with in-order multi-lane dispatch and up to COMMIT_WIDTH same-cycle in-order commits.
- Adds selective branch recovery: tail rolls back to a mispredicted branch, and only younger entries are squashed.
- Commit-time exception/mispredict flush clears the whole buffer.
- Sits between rename/dispatch, the writeback (CDB) network and retirement (arch map table, free list).

---
 rtl/rob_nway_recover.sv | 247 ++++++++++++++++++++++++
 tb/tb_rob_nway_recover.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_nway_recover.sv
// N-wide reorder buffer: multi-lane in-order dispatch, in-order multi-lane commit,
// commit-time full flush, and selective branch recovery that squashes younger entries.
module rob_nway_recover #(
   parameter int unsigned DEPTH          = 32,
   parameter int unsigned DISPATCH_WIDTH = 2,
   parameter int unsigned COMMIT_WIDTH   = 2,
   parameter int unsigned WB_WIDTH       = 4,
   parameter int unsigned ARCH_REGS      = 32,
   parameter int unsigned PHYS_REGS      = 64,
   localparam int unsigned AW   = $clog2(ARCH_REGS),
   localparam int unsigned PW   = $clog2(PHYS_REGS),
   localparam int unsigned IW   = $clog2(DEPTH),
   localparam int unsigned CNTW = $clog2(DEPTH + 1)
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic [DISPATCH_WIDTH-1:0]      disp_valid_i,
   input  logic [DISPATCH_WIDTH-1:0]      disp_rd_wen_i,
   input  logic [DISPATCH_WIDTH*AW-1:0]   disp_rd_arch_i,
   input  logic [DISPATCH_WIDTH*PW-1:0]   disp_new_prf_i,
   input  logic [DISPATCH_WIDTH*PW-1:0]   disp_old_prf_i,
   output logic [DISPATCH_WIDTH-1:0]      disp_alloc_o,
   output logic [DISPATCH_WIDTH*IW-1:0]   disp_rob_idx_o,
   output logic [CNTW-1:0]                free_slots_o,
   input  logic [WB_WIDTH-1:0]            wb_valid_i,
   input  logic [WB_WIDTH*IW-1:0]         wb_rob_idx_i,
   input  logic [WB_WIDTH-1:0]            wb_exception_i,
   input  logic [WB_WIDTH-1:0]            wb_mispred_i,
   input  logic                           br_recover_valid_i,
   input  logic [IW-1:0]                  br_recover_rob_idx_i,
   output logic [COMMIT_WIDTH-1:0]        commit_valid_o,
   output logic [COMMIT_WIDTH-1:0]        commit_rd_wen_o,
   output logic [COMMIT_WIDTH*AW-1:0]     commit_rd_arch_o,
   output logic [COMMIT_WIDTH*PW-1:0]     commit_new_prf_o,
   output logic [COMMIT_WIDTH*PW-1:0]     commit_old_prf_o,
   output logic [COMMIT_WIDTH*IW-1:0]     commit_rob_idx_o,
   output logic                           flush_o,
   output logic [IW-1:0]                  flush_rob_idx_o,
   output logic [CNTW-1:0]                count_o,
   output logic                           empty_o,
   output logic                           full_o
);

   // (a + b) mod DEPTH for a, b < DEPTH; exact for non-power-of-two DEPTH
   function automatic logic [IW-1:0] idx_add(input logic [IW-1:0] a, input logic [IW-1:0] b);
      logic [IW:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= (IW+1)'(DEPTH)) s = s - (IW+1)'(DEPTH);
      return s[IW-1:0];
   endfunction

   // (a - h) mod DEPTH: age of slot a relative to head h
   function automatic logic [IW-1:0] idx_dist(input logic [IW-1:0] a, input logic [IW-1:0] h);
      logic [IW:0] s;
      if (a >= h) s = {1'b0, a} - {1'b0, h};
      else        s = {1'b0, a} + (IW+1)'(DEPTH) - {1'b0, h};
      return s[IW-1:0];
   endfunction

   logic [IW-1:0]    head_q, head_d, tail_q, tail_d;
   logic [CNTW-1:0]  count_q, count_d;
   logic [DEPTH-1:0] valid_q, valid_d, ready_q, ready_d;
   logic [DEPTH-1:0] exc_q, exc_d, mis_q, mis_d, wen_q, wen_d;
   logic [AW-1:0]    arch_q [DEPTH];
   logic [AW-1:0]    arch_d [DEPTH];
   logic [PW-1:0]    new_q  [DEPTH];
   logic [PW-1:0]    new_d  [DEPTH];
   logic [PW-1:0]    old_q  [DEPTH];
   logic [PW-1:0]    old_d  [DEPTH];

   logic [COMMIT_WIDTH-1:0]   cm_vld;
   logic [IW-1:0]             cm_idx [COMMIT_WIDTH];
   logic [CNTW-1:0]           n_commit;
   logic                      cm_block;
   logic                      flush;
   logic [IW-1:0]             flush_idx;
   logic [DISPATCH_WIDTH-1:0] grant;
   logic [IW-1:0]             d_idx [DISPATCH_WIDTH];
   logic [CNTW-1:0]           n_grant;
   logic                      g_block;
   logic [CNTW-1:0]           free_slots;
   logic [IW-1:0]             br_dist;

   assign free_slots = CNTW'(DEPTH) - count_q;

   // Commit selection: contiguous ready lanes from head; a flagged lane ends the group
   always_comb begin
      cm_vld    = '0;
      n_commit  = '0;
      cm_block  = 1'b0;
      flush     = 1'b0;
      flush_idx = '0;
      for (int i = 0; i < COMMIT_WIDTH; i++) begin
         cm_idx[i] = idx_add(head_q, IW'(i));
         if (!cm_block && valid_q[cm_idx[i]] && ready_q[cm_idx[i]]) begin
            cm_vld[i] = 1'b1;
            n_commit  = n_commit + CNTW'(1);
            if (exc_q[cm_idx[i]] || mis_q[cm_idx[i]]) begin
               flush     = 1'b1;
               flush_idx = cm_idx[i];
               cm_block  = 1'b1;
            end
         end else begin
            cm_block = 1'b1;
         end
      end
   end

   // Dispatch grant: contiguous lanes while slots remain; blocked by reset, flush, recovery
   always_comb begin
      grant   = '0;
      n_grant = '0;
      g_block = reset || flush || br_recover_valid_i;
      for (int i = 0; i < DISPATCH_WIDTH; i++) begin
         d_idx[i] = idx_add(tail_q, IW'(i));
         if (!g_block && disp_valid_i[i] && (CNTW'(i) < free_slots)) begin
            grant[i] = 1'b1;
            n_grant  = n_grant + CNTW'(1);
         end else begin
            g_block = 1'b1;
         end
      end
   end

   // Next state: writeback, retirement, then flush / recovery / dispatch by priority
   always_comb begin
      head_d  = idx_add(head_q, IW'(n_commit));
      tail_d  = tail_q;
      count_d = count_q;
      valid_d = valid_q;
      ready_d = ready_q;
      exc_d   = exc_q;
      mis_d   = mis_q;
      wen_d   = wen_q;
      arch_d  = arch_q;
      new_d   = new_q;
      old_d   = old_q;
      br_dist = idx_dist(br_recover_rob_idx_i, head_q);

      for (int p = 0; p < WB_WIDTH; p++) begin
         if (wb_valid_i[p] && valid_q[wb_rob_idx_i[p*IW +: IW]]) begin
            ready_d[wb_rob_idx_i[p*IW +: IW]] = 1'b1;
            exc_d[wb_rob_idx_i[p*IW +: IW]]   = exc_d[wb_rob_idx_i[p*IW +: IW]] | wb_exception_i[p];
            mis_d[wb_rob_idx_i[p*IW +: IW]]   = mis_d[wb_rob_idx_i[p*IW +: IW]] | wb_mispred_i[p];
         end
      end

      for (int i = 0; i < COMMIT_WIDTH; i++) begin
         if (cm_vld[i]) valid_d[cm_idx[i]] = 1'b0;
      end

      if (flush) begin
         valid_d = '0;
         ready_d = '0;
         exc_d   = '0;
         mis_d   = '0;
         head_d  = idx_add(flush_idx, IW'(1));
         tail_d  = idx_add(flush_idx, IW'(1));
         count_d = '0;
      end else if (br_recover_valid_i) begin
         // Squash everything strictly younger than the branch; the branch survives
         for (int j = 0; j < DEPTH; j++) begin
            if (idx_dist(IW'(j), head_q) > br_dist) begin
               valid_d[j] = 1'b0;
               ready_d[j] = 1'b0;
            end
         end
         tail_d  = idx_add(br_recover_rob_idx_i, IW'(1));
         count_d = CNTW'(br_dist) + CNTW'(1) - n_commit;
      end else begin
         for (int i = 0; i < DISPATCH_WIDTH; i++) begin
            if (grant[i]) begin
               valid_d[d_idx[i]] = 1'b1;
               ready_d[d_idx[i]] = 1'b0;
               exc_d[d_idx[i]]   = 1'b0;
               mis_d[d_idx[i]]   = 1'b0;
               wen_d[d_idx[i]]   = disp_rd_wen_i[i];
               arch_d[d_idx[i]]  = disp_rd_arch_i[i*AW +: AW];
               new_d[d_idx[i]]   = disp_new_prf_i[i*PW +: PW];
               old_d[d_idx[i]]   = disp_old_prf_i[i*PW +: PW];
            end
         end
         tail_d  = idx_add(tail_q, IW'(n_grant));
         count_d = count_q + n_grant - n_commit;
      end
   end

   // State registers with asynchronous active-high reset
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         valid_q <= '0;
         ready_q <= '0;
         exc_q   <= '0;
         mis_q   <= '0;
         wen_q   <= '0;
         for (int j = 0; j < DEPTH; j++) begin
            arch_q[j] <= '0;
            new_q[j]  <= '0;
            old_q[j]  <= '0;
         end
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         valid_q <= valid_d;
         ready_q <= ready_d;
         exc_q   <= exc_d;
         mis_q   <= mis_d;
         wen_q   <= wen_d;
         arch_q  <= arch_d;
         new_q   <= new_d;
         old_q   <= old_d;
      end
   end

   // Output drive; commit payload is zeroed on idle lanes
   always_comb begin
      disp_alloc_o     = grant;
      disp_rob_idx_o   = '0;
      commit_valid_o   = cm_vld;
      commit_rd_wen_o  = '0;
      commit_rd_arch_o = '0;
      commit_new_prf_o = '0;
      commit_old_prf_o = '0;
      commit_rob_idx_o = '0;
      for (int i = 0; i < DISPATCH_WIDTH; i++) disp_rob_idx_o[i*IW +: IW] = d_idx[i];
      for (int i = 0; i < COMMIT_WIDTH; i++) begin
         if (cm_vld[i]) begin
            commit_rd_wen_o[i]             = wen_q[cm_idx[i]];
            commit_rd_arch_o[i*AW +: AW]   = arch_q[cm_idx[i]];
            commit_new_prf_o[i*PW +: PW]   = new_q[cm_idx[i]];
            commit_old_prf_o[i*PW +: PW]   = old_q[cm_idx[i]];
            commit_rob_idx_o[i*IW +: IW]   = cm_idx[i];
         end
      end
      flush_o         = flush;
      flush_rob_idx_o = flush_idx;
      free_slots_o    = free_slots;
      count_o         = count_q;
      empty_o         = (count_q == '0);
      full_o          = (count_q == CNTW'(DEPTH));
   end

endmodule

// File: tb/tb_rob_nway_recover.sv
// Directed bench for rob_nway_recover (DEPTH=8, 2 dispatch, 2 commit lanes) with a
// commit scoreboard: expected retirements are queued as stimulus is issued and a
// negedge monitor pops and compares every committing lane.
module tb_rob_nway_recover;

   logic        clock = 1'b0;
   logic        reset;
   logic [1:0]  disp_valid_i, disp_rd_wen_i, disp_alloc_o;
   logic [9:0]  disp_rd_arch_i;
   logic [11:0] disp_new_prf_i, disp_old_prf_i;
   logic [5:0]  disp_rob_idx_o;
   logic [3:0]  free_slots_o;
   logic [3:0]  wb_valid_i, wb_exception_i, wb_mispred_i;
   logic [11:0] wb_rob_idx_i;
   logic        br_recover_valid_i;
   logic [2:0]  br_recover_rob_idx_i;
   logic [1:0]  commit_valid_o, commit_rd_wen_o;
   logic [9:0]  commit_rd_arch_o;
   logic [11:0] commit_new_prf_o, commit_old_prf_o;
   logic [5:0]  commit_rob_idx_o;
   logic        flush_o;
   logic [2:0]  flush_rob_idx_o;
   logic [3:0]  count_o;
   logic        empty_o, full_o;

   rob_nway_recover #(
      .DEPTH(8), .DISPATCH_WIDTH(2), .COMMIT_WIDTH(2), .WB_WIDTH(4),
      .ARCH_REGS(32), .PHYS_REGS(64)
   ) dut (
      .clock(clock), .reset(reset),
      .disp_valid_i(disp_valid_i), .disp_rd_wen_i(disp_rd_wen_i),
      .disp_rd_arch_i(disp_rd_arch_i), .disp_new_prf_i(disp_new_prf_i),
      .disp_old_prf_i(disp_old_prf_i), .disp_alloc_o(disp_alloc_o),
      .disp_rob_idx_o(disp_rob_idx_o), .free_slots_o(free_slots_o),
      .wb_valid_i(wb_valid_i), .wb_rob_idx_i(wb_rob_idx_i),
      .wb_exception_i(wb_exception_i), .wb_mispred_i(wb_mispred_i),
      .br_recover_valid_i(br_recover_valid_i), .br_recover_rob_idx_i(br_recover_rob_idx_i),
      .commit_valid_o(commit_valid_o), .commit_rd_wen_o(commit_rd_wen_o),
      .commit_rd_arch_o(commit_rd_arch_o), .commit_new_prf_o(commit_new_prf_o),
      .commit_old_prf_o(commit_old_prf_o), .commit_rob_idx_o(commit_rob_idx_o),
      .flush_o(flush_o), .flush_rob_idx_o(flush_rob_idx_o),
      .count_o(count_o), .empty_o(empty_o), .full_o(full_o)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int failures = 0;
   int seq = 0;
   int m_tail = 0;
   logic [17:0] exp_pl [8];   // {wen, arch, new, old} recorded per slot at dispatch
   logic [21:0] sb_q [$];     // {flush, payload, idx}
   logic [21:0] mon_act, mon_exp;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic clear_inputs();
      disp_valid_i = '0; disp_rd_wen_i = '0; disp_rd_arch_i = '0;
      disp_new_prf_i = '0; disp_old_prf_i = '0;
      wb_valid_i = '0; wb_rob_idx_i = '0; wb_exception_i = '0; wb_mispred_i = '0;
      br_recover_valid_i = 1'b0; br_recover_rob_idx_i = '0;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
      clear_inputs();
   endtask

   // Drive dispatch lanes, check grant and indices, record expected payload
   task automatic disp_set(input logic [1:0] v, input logic [1:0] ea);
      int s, ix, n;
      disp_valid_i = v;
      for (int l = 0; l < 2; l++) begin
         s = seq + l;
         disp_rd_wen_i[l]          = ~s[0];
         disp_rd_arch_i[l*5 +: 5]  = 5'(s + 3);
         disp_new_prf_i[l*6 +: 6]  = 6'(s + 32);
         disp_old_prf_i[l*6 +: 6]  = 6'(s + 7);
      end
      #1;
      check("disp_alloc", disp_alloc_o, ea);
      for (int l = 0; l < 2; l++) begin
         if (ea[l]) begin
            ix = (m_tail + l) % 8;
            check("disp_idx", disp_rob_idx_o[l*3 +: 3], ix);
            exp_pl[ix] = {disp_rd_wen_i[l], disp_rd_arch_i[l*5 +: 5],
                          disp_new_prf_i[l*6 +: 6], disp_old_prf_i[l*6 +: 6]};
         end
      end
      n = int'(ea[0]) + int'(ea[1]);
      m_tail = (m_tail + n) % 8;
      seq = seq + n;
   endtask

   task automatic wb_set(input int port, input int idx, input bit exc, input bit mis);
      wb_valid_i[port]         = 1'b1;
      wb_rob_idx_i[port*3 +: 3] = 3'(idx);
      wb_exception_i[port]     = exc;
      wb_mispred_i[port]       = mis;
   endtask

   task automatic expect_commit(input int idx, input bit fl);
      sb_q.push_back({fl, exp_pl[idx], 3'(idx)});
   endtask

   // Monitor: every committing lane must match the next queued expectation
   initial begin
      forever begin
         @(negedge clock);
         if (!reset) begin
            for (int l = 0; l < 2; l++) begin
               if (commit_valid_o[l]) begin
                  mon_act = {flush_o && (flush_rob_idx_o == commit_rob_idx_o[l*3 +: 3]),
                             commit_rd_wen_o[l], commit_rd_arch_o[l*5 +: 5],
                             commit_new_prf_o[l*6 +: 6], commit_old_prf_o[l*6 +: 6],
                             commit_rob_idx_o[l*3 +: 3]};
                  if (sb_q.size() == 0) begin
                     checks++;
                     failures++;
                     $display("FAIL commit_unexpected: got lane %0d idx %0d expected none",
                              l, commit_rob_idx_o[l*3 +: 3]);
                  end else begin
                     mon_exp = sb_q.pop_front();
                     check("commit", mon_act, mon_exp);
                  end
               end
            end
         end
      end
   end

   initial begin
      clear_inputs();
      reset = 1'b1;
      #2;
      check("rst_count", count_o, 0);
      check("rst_empty", empty_o, 1);
      check("rst_full", full_o, 0);
      check("rst_free", free_slots_o, 8);
      check("rst_commit", commit_valid_o, 0);
      check("rst_flush", flush_o, 0);
      disp_valid_i = 2'b11;
      #1;
      check("rst_alloc", disp_alloc_o, 0);
      disp_valid_i = 2'b00;
      #9;
      reset = 1'b0;
      tick();

      // Fill: 2 per cycle -> idx 0..7, then full and refuses a 5th request
      for (int c = 0; c < 4; c++) begin
         disp_set(2'b11, 2'b11);
         tick();
      end
      check("fill_count", count_o, 8);
      check("fill_full", full_o, 1);
      check("fill_free", free_slots_o, 0);
      disp_set(2'b11, 2'b00);
      tick();

      // Out-of-order wb: idx 1 alone commits nothing; idx 0 releases both in order
      wb_set(0, 1, 0, 0);
      tick();
      check("no_commit_yet", commit_valid_o, 2'b00);
      wb_set(0, 0, 0, 0);
      expect_commit(0, 0);
      expect_commit(1, 0);
      tick();
      check("pair_commit", commit_valid_o, 2'b11);
      check("pair_count_before", count_o, 8);
      tick();
      check("pair_count_after", count_o, 6);

      // Refill to full, then asynchronous reset mid-cycle with wb pending
      disp_set(2'b11, 2'b11);
      tick();
      check("refill_full", full_o, 1);
      wb_set(0, 2, 0, 0);
      wb_set(1, 3, 0, 0);
      disp_valid_i = 2'b11;
      #1;
      reset = 1'b1;
      #1;
      check("arst_count", count_o, 0);
      check("arst_empty", empty_o, 1);
      check("arst_full", full_o, 0);
      check("arst_free", free_slots_o, 8);
      check("arst_commit", commit_valid_o, 0);
      check("arst_alloc", disp_alloc_o, 0);
      tick();
      #2;
      reset = 1'b0;
      m_tail = 0;
      tick();

      // Flush: 0..5 allocated; 0,1 commit, then mispredicted 2 flushes
      for (int c = 0; c < 3; c++) begin
         disp_set(2'b11, 2'b11);
         tick();
      end
      wb_set(0, 0, 0, 0);
      wb_set(1, 1, 0, 0);
      wb_set(2, 2, 0, 1);
      expect_commit(0, 0);
      expect_commit(1, 0);
      expect_commit(2, 1);
      tick();
      check("pre_flush_commit", commit_valid_o, 2'b11);
      check("pre_flush_flag", flush_o, 0);
      tick();
      check("flush_flag", flush_o, 1);
      check("flush_idx", flush_rob_idx_o, 2);
      check("flush_lanes", commit_valid_o, 2'b01);
      disp_set(2'b11, 2'b00);
      tick();
      m_tail = 3;
      check("post_flush_count", count_o, 0);
      check("post_flush_empty", empty_o, 1);

      // Drain 3,4,5 to move head to 6
      disp_set(2'b11, 2'b11);
      tick();
      disp_set(2'b01, 2'b01);
      tick();
      wb_set(0, 3, 0, 0);
      wb_set(1, 4, 0, 0);
      wb_set(3, 5, 0, 0);
      expect_commit(3, 0);
      expect_commit(4, 0);
      expect_commit(5, 0);
      tick();
      tick();
      tick();
      check("drain_empty", empty_o, 1);

      // Wrap: 6,7,0,1,2; recover at branch 7 squashes 0..2
      disp_set(2'b11, 2'b11);
      tick();
      disp_set(2'b11, 2'b11);
      tick();
      disp_set(2'b01, 2'b01);
      tick();
      check("wrap_count", count_o, 5);
      br_recover_valid_i   = 1'b1;
      br_recover_rob_idx_i = 3'd7;
      wb_set(0, 1, 0, 0);
      disp_set(2'b11, 2'b00);
      tick();
      m_tail = 0;
      check("recover_count", count_o, 2);
      wb_set(0, 6, 0, 0);
      wb_set(1, 7, 0, 0);
      expect_commit(6, 0);
      expect_commit(7, 0);
      tick();
      tick();
      check("recover_drain", count_o, 0);
      wb_set(2, 0, 0, 0);
      tick();
      tick();
      check("squashed_no_commit", commit_valid_o, 2'b00);
      check("squashed_count", count_o, 0);

      // Recovery in the same cycle as a head commit
      disp_set(2'b11, 2'b11);
      tick();
      disp_set(2'b11, 2'b11);
      tick();
      check("e_count", count_o, 4);
      wb_set(0, 0, 0, 0);
      expect_commit(0, 0);
      tick();
      br_recover_valid_i   = 1'b1;
      br_recover_rob_idx_i = 3'd2;
      tick();
      m_tail = 3;
      check("recover_commit_count", count_o, 2);
      disp_set(2'b01, 2'b01);
      tick();
      check("after_recover_count", count_o, 3);

      // Flagged commit wins over a same-cycle recovery request
      wb_set(0, 1, 1, 0);
      expect_commit(1, 1);
      tick();
      check("exc_flush_flag", flush_o, 1);
      check("exc_flush_idx", flush_rob_idx_o, 1);
      br_recover_valid_i   = 1'b1;
      br_recover_rob_idx_i = 3'd2;
      tick();
      m_tail = 2;
      check("exc_count", count_o, 0);
      check("exc_empty", empty_o, 1);
      disp_set(2'b01, 2'b01);
      tick();
      tick();
      tick();
      check("scoreboard_drained", sb_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
